pll_lock_sequencer: RTL and testbench

Sequences the UART/SAR PLL through reset, lock acquisition and lock qualification, running on the 12 MHz board reference clock so it keeps working when the PLL output is absent. Drives the PLL `RESETB` pin, synchronises and debounces the PLL `locked` flag, and publishes a single `ready` qualifier that gates the reset release of every 36.75 MHz-domain block. Repeated lock-acquisition failures end in a latched fault that is cleared only by `restart` or reset.

---
 rtl/pll_lock_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
// PLL reset, lock acquisition and lock qualification sequencer. Runs entirely on the
// 12 MHz reference clock so it keeps working while the PLL output is absent.
module pll_lock_sequencer #(
    parameter int RESET_CYCLES = 16,
    parameter int LOCK_STABLE  = 1024,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int MAX_RETRIES  = 3,
    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
    input  logic          clock_in,
    input  logic          reset_n,
    input  logic          locked_in,
    input  logic          restart,
    output logic          pll_resetb,
    output logic          ready,
    output logic          fault,
    output logic [RW-1:0] retry_count,
    output logic [2:0]    state
);

    localparam int MAX_A   = (RESET_CYCLES > LOCK_STABLE) ? RESET_CYCLES : LOCK_STABLE;
    localparam int MAX_CNT = (MAX_A > LOCK_TIMEOUT) ? MAX_A : LOCK_TIMEOUT;
    localparam int CW      = $clog2(MAX_CNT + 1);

    localparam logic [CW-1:0] RST_LAST  = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] STB_LAST  = CW'(LOCK_STABLE - 1);
    localparam logic [CW-1:0] TMO_LAST  = CW'(LOCK_TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_READY     = 3'd3,
        ST_FAULT     = 3'd4
    } state_e;

    logic [1:0]    sync_q;
    logic [1:0]    sync_d;
    logic          lock_s;
    state_e        state_q;
    state_e        state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [RW-1:0] retry_q;
    logic [RW-1:0] retry_d;
    logic          pll_resetb_q;
    logic          pll_resetb_d;
    logic          ready_q;
    logic          ready_d;
    logic          fault_q;
    logic          fault_d;

    // Two-flop synchroniser input shift for the asynchronous PLL lock flag.
    always_comb begin
        sync_d = {sync_q[0], locked_in};
    end

    assign lock_s = sync_q[1];

    // Next-state, cycle counter and retry bookkeeping.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        retry_d = retry_q;
        case (state_q)
            ST_RESET_PLL: begin
                if (cnt_q >= RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    state_d = ST_RESET_PLL;
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = ST_STABLE;
                    cnt_d   = {CW{1'b0}};
                end else if (cnt_q >= TMO_LAST) begin
                    cnt_d = {CW{1'b0}};
                    if (retry_q == RETRY_MAX) begin
                        state_d = ST_FAULT;
                    end else begin
                        state_d = ST_RESET_PLL;
                        retry_d = retry_q + RW'(1);
                    end
                end else begin
                    state_d = ST_WAIT_LOCK;
                end
            end
            ST_STABLE: begin
                // A drop always wins, even on the cycle that would have qualified.
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = {CW{1'b0}};
                end else if (cnt_q >= STB_LAST) begin
                    state_d = ST_READY;
                    cnt_d   = {CW{1'b0}};
                    retry_d = {RW{1'b0}};
                end else begin
                    state_d = ST_STABLE;
                end
            end
            ST_READY: begin
                cnt_d = {CW{1'b0}};
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                end else begin
                    state_d = ST_READY;
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
                cnt_d   = {CW{1'b0}};
            end
            default: begin
                state_d = ST_RESET_PLL;
                cnt_d   = {CW{1'b0}};
                retry_d = {RW{1'b0}};
            end
        endcase
        if (restart) begin
            state_d = ST_RESET_PLL;
            cnt_d   = {CW{1'b0}};
            retry_d = {RW{1'b0}};
        end else begin
            retry_d = retry_d;
        end
    end

    // Output values decoded from the next state so they register on the same edge.
    always_comb begin
        pll_resetb_d = 1'b0;
        ready_d      = 1'b0;
        fault_d      = 1'b0;
        case (state_d)
            ST_WAIT_LOCK, ST_STABLE: begin
                pll_resetb_d = 1'b1;
            end
            ST_READY: begin
                pll_resetb_d = 1'b1;
                ready_d      = 1'b1;
            end
            ST_FAULT: begin
                fault_d = 1'b1;
            end
            default: begin
                pll_resetb_d = 1'b0;
            end
        endcase
    end

    // State, counter, synchroniser and output registers.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            sync_q       <= 2'b00;
            state_q      <= ST_RESET_PLL;
            cnt_q        <= {CW{1'b0}};
            retry_q      <= {RW{1'b0}};
            pll_resetb_q <= 1'b0;
            ready_q      <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retry_q      <= retry_d;
            pll_resetb_q <= pll_resetb_d;
            ready_q      <= ready_d;
            fault_q      <= fault_d;
        end
    end

    assign pll_resetb  = pll_resetb_q;
    assign ready       = ready_q;
    assign fault       = fault_q;
    assign retry_count = retry_q;
    assign state       = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: directed vector table plus randomized lock/restart
// traffic checked every cycle against a behavioural model.
module tb_pll_lock_sequencer;

    localparam int RC = 4;
    localparam int LS = 8;
    localparam int LT = 32;
    localparam int MR = 2;

    logic       clock_in = 1'b0;
    logic       reset_n  = 1'b0;
    logic       locked_in = 1'b0;
    logic       restart  = 1'b0;
    logic       pll_resetb;
    logic       ready;
    logic       fault;
    logic [1:0] retry_count;
    logic [2:0] state;

    int n_tests = 0;
    int n_fail  = 0;

    pll_lock_sequencer #(
        .RESET_CYCLES(RC),
        .LOCK_STABLE (LS),
        .LOCK_TIMEOUT(LT),
        .MAX_RETRIES (MR)
    ) dut (
        .clock_in   (clock_in),
        .reset_n    (reset_n),
        .locked_in  (locked_in),
        .restart    (restart),
        .pll_resetb (pll_resetb),
        .ready      (ready),
        .fault      (fault),
        .retry_count(retry_count),
        .state      (state)
    );

    always #5 clock_in = ~clock_in;

    // Behavioural model: phase (0..4), cycles spent in phase, retries, lock delay line.
    int   m_phase;
    int   m_time;
    int   m_retry;
    logic m_dly[2];

    function automatic void model_reset();
        m_phase  = 0;
        m_time   = 0;
        m_retry  = 0;
        m_dly[0] = 1'b0;
        m_dly[1] = 1'b0;
    endfunction

    function automatic void model_step();
        logic lk;
        lk = m_dly[1];
        if (restart) begin
            m_phase = 0;
            m_time  = 0;
            m_retry = 0;
        end else if (m_phase == 0) begin
            m_time++;
            if (m_time == RC) begin
                m_phase = 1;
                m_time  = 0;
            end
        end else if (m_phase == 1) begin
            if (lk) begin
                m_phase = 2;
                m_time  = 0;
            end else begin
                m_time++;
                if (m_time == LT) begin
                    m_time = 0;
                    if (m_retry == MR) m_phase = 4;
                    else begin
                        m_retry++;
                        m_phase = 0;
                    end
                end
            end
        end else if (m_phase == 2) begin
            if (!lk) begin
                m_phase = 1;
                m_time  = 0;
            end else begin
                m_time++;
                if (m_time == LS) begin
                    m_phase = 3;
                    m_time  = 0;
                    m_retry = 0;
                end
            end
        end else if (m_phase == 3) begin
            if (!lk) begin
                m_phase = 1;
                m_time  = 0;
            end
        end
        m_dly[1] = m_dly[0];
        m_dly[0] = locked_in;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_in);
        model_step();
        #1;
    endtask

    // Reset is released 1 time unit after a rising edge, as an external synchroniser would.
    task automatic do_reset();
        restart = 1'b0;
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clock_in);
        #1;
        reset_n = 1'b1;
    endtask

    typedef struct {
        int         ncyc;
        logic       lk;
        logic       rs;
        logic [2:0] st;
        logic       rdy;
        logic       flt;
        logic       rb;
        logic [1:0] rc;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(int n, int lk, int rs, int st, int rdy, int flt, int rb, int rc);
        vec_t v;
        v.ncyc = n;
        v.lk   = 1'(lk);
        v.rs   = 1'(rs);
        v.st   = 3'(st);
        v.rdy  = 1'(rdy);
        v.flt  = 1'(flt);
        v.rb   = 1'(rb);
        v.rc   = 2'(rc);
        vecs.push_back(v);
    endfunction

    initial begin
        int seg;
        logic [7:0] got;
        logic [7:0] exp;

        // Rows: ticks to run, locked_in, restart (first tick only), expected outputs after.
        // Power-up with lock present: ready on tick 13, i.e. the 14th edge counting the release edge.
        add(3, 1,0, 0,0,0,0,0);
        add(1, 1,0, 1,0,0,1,0);
        add(1, 1,0, 2,0,0,1,0);
        add(7, 1,0, 2,0,0,1,0);
        add(1, 1,0, 3,1,0,1,0);
        add(5, 1,0, 3,1,0,1,0);
        // Lock lost in READY: ready drops on the 3rd edge; relock after 10 cycles.
        add(2, 0,0, 3,1,0,1,0);
        add(1, 0,0, 1,0,0,1,0);
        add(7, 0,0, 1,0,0,1,0);
        add(2, 1,0, 1,0,0,1,0);
        add(1, 1,0, 2,0,0,1,0);
        add(7, 1,0, 2,0,0,1,0);
        add(1, 1,0, 3,1,0,1,0);
        // Restart, then 3-cycle glitch after 5 STABLE cycles.
        add(1, 1,1, 0,0,0,0,0);
        add(4, 1,0, 1,0,0,1,0);
        add(1, 1,0, 2,0,0,1,0);
        add(4, 1,0, 2,0,0,1,0);
        add(2, 0,0, 2,0,0,1,0);
        add(1, 0,0, 1,0,0,1,0);
        add(2, 1,0, 1,0,0,1,0);
        add(1, 1,0, 2,0,0,1,0);
        add(7, 1,0, 2,0,0,1,0);
        add(1, 1,0, 3,1,0,1,0);
        // Restart mid-STABLE and full rerun.
        add(1, 1,1, 0,0,0,0,0);
        add(4, 1,0, 1,0,0,1,0);
        add(1, 1,0, 2,0,0,1,0);
        add(3, 1,0, 2,0,0,1,0);
        add(1, 1,1, 0,0,0,0,0);
        add(4, 1,0, 1,0,0,1,0);
        add(1, 1,0, 2,0,0,1,0);
        add(7, 1,0, 2,0,0,1,0);
        add(1, 1,0, 3,1,0,1,0);
        // Lock drop seen on the last STABLE cycle: back to WAIT_LOCK, never READY.
        add(1, 1,1, 0,0,0,0,0);
        add(4, 1,0, 1,0,0,1,0);
        add(1, 1,0, 2,0,0,1,0);
        add(5, 1,0, 2,0,0,1,0);
        add(2, 0,0, 2,0,0,1,0);
        add(1, 0,0, 1,0,0,1,0);
        // Lock never arrives: retries 36 cycles apart, then latched fault.
        add(1, 0,1, 0,0,0,0,0);
        add(4, 0,0, 1,0,0,1,0);
        add(31,0,0, 1,0,0,1,0);
        add(1, 0,0, 0,0,0,0,1);
        add(3, 0,0, 0,0,0,0,1);
        add(1, 0,0, 1,0,0,1,1);
        add(31,0,0, 1,0,0,1,1);
        add(1, 0,0, 0,0,0,0,2);
        add(4, 0,0, 1,0,0,1,2);
        add(31,0,0, 1,0,0,1,2);
        add(1, 0,0, 4,0,1,0,2);
        add(20,1,0, 4,0,1,0,2);
        // Restart out of FAULT and full rerun.
        add(1, 1,1, 0,0,0,0,0);
        add(4, 1,0, 1,0,0,1,0);
        add(1, 1,0, 2,0,0,1,0);
        add(7, 1,0, 2,0,0,1,0);
        add(1, 1,0, 3,1,0,1,0);

        model_reset();
        locked_in = 1'b1;
        #1;
        chk("por.state", state, 0);
        chk("por.pll_resetb", pll_resetb, 0);
        chk("por.ready", ready, 0);
        chk("por.fault", fault, 0);
        chk("por.retry", retry_count, 0);

        do_reset();
        chk("rel.state", state, 0);
        chk("rel.pll_resetb", pll_resetb, 0);

        foreach (vecs[i]) begin
            locked_in = vecs[i].lk;
            restart   = vecs[i].rs;
            for (int c = 0; c < vecs[i].ncyc; c++) begin
                tick();
                restart = 1'b0;
            end
            chk($sformatf("vec%0d.state", i), state, vecs[i].st);
            chk($sformatf("vec%0d.ready", i), ready, vecs[i].rdy);
            chk($sformatf("vec%0d.fault", i), fault, vecs[i].flt);
            chk($sformatf("vec%0d.pll_resetb", i), pll_resetb, vecs[i].rb);
            chk($sformatf("vec%0d.retry", i), retry_count, vecs[i].rc);
        end

        // Asynchronous reset between edges while READY.
        locked_in = 1'b1;
        do_reset();
        repeat (13) tick();
        chk("arst.pre_ready", ready, 1);
        @(negedge clock_in);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("arst.ready", ready, 0);
        chk("arst.pll_resetb", pll_resetb, 0);
        chk("arst.state", state, 0);
        @(posedge clock_in);
        #1;
        reset_n = 1'b1;

        // Randomized lock/restart traffic against the model, every cycle.
        do_reset();
        seg = 0;
        for (int i = 0; i < 4000; i++) begin
            if (seg == 0) begin
                locked_in = ($urandom_range(0, 3) != 0);
                seg = ($urandom_range(0, 9) == 0) ? int'($urandom_range(100, 160))
                                                  : int'($urandom_range(1, 20));
            end
            restart = ($urandom_range(0, 149) == 0);
            tick();
            seg--;
            got = {state, ready, fault, pll_resetb, retry_count};
            exp = {3'(m_phase), 1'(m_phase == 3), 1'(m_phase == 4),
                   1'(m_phase == 1 || m_phase == 2 || m_phase == 3), 2'(m_retry)};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL rand%0d {state,ready,fault,pll_resetb,retry}: got %b expected %b",
                         i, got, exp);
            end
        end
        restart = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
